dmem_img_reader: RTL and testbench
==================================

// Module: dmem_img_reader
// PURPOSE
//   Read-side counterpart to the camera capture path. The capture FSM writes the downsampled
//   28x28 image into DMEM as packed 256-bit words. This block reads those words back and
//   unpacks them into 8-bit pixels, then streams them out on a valid/ready byte interface.
//   The byte interface feeds the SPART transmitter or the NN input. Started by the CPU.
// PARAMETERS
//   BASE_ADDR   0    DMEM word address of pixel 0 (7-bit)
//   NUM_PIXELS  784  pixels per image (1..4096); words read = ceil(NUM_PIXELS/32)
// PORTS
//   CLOCK_50     in   1    system clock; all logic on posedge
//   rst_n        in   1    asynchronous active-low reset
//   start        in   1    CPU request; sampled only in IDLE
//   busy         out  1    high in every state except IDLE
//   done         out  1    one-cycle pulse when the last pixel has been handshaken
//   dmem_rden    out  1    DMEM read enable, one cycle per word
//   dmem_rdaddr  out  7    DMEM word address, valid while dmem_rden is high
//   dmem_rddata  in   256  DMEM read data, valid the cycle after dmem_rden
//   tx_data      out  8    current pixel
//   tx_valid     out  1    tx_data valid
//   tx_ready     in   1    consumer accepts tx_data when tx_valid && tx_ready
//   pix_cnt      out  12   pixels accepted so far in the current image
// BEHAVIOUR
//   Reset: state=IDLE; all outputs 0, including busy, done, dmem_rden, dmem_rdaddr, tx_*, pix_cnt.
//   Word layout: pixel (32*k + j) is in word BASE_ADDR+k, bits [8j+7:8j]. Pixel 0 = bits [7:0].
//   FSM states: IDLE -> READ -> WAIT -> SEND -> (READ | DONE) -> IDLE
//     IDLE: start=1 -> clear pix_cnt and byte_idx; addr <= BASE_ADDR; go to READ.
//     READ: dmem_rden=1 and dmem_rdaddr=addr for exactly one cycle; go to WAIT.
//     WAIT: latch dmem_rddata into a 256-bit shift buffer; byte_idx <= 0; go to SEND.
//     SEND: tx_valid=1, tx_data=buf[7:0]. On handshake: buf >>= 8, byte_idx++, pix_cnt++.
//           If handshake with pix_cnt==NUM_PIXELS-1 -> go to DONE (takes priority).
//           Else if handshake with byte_idx==31 -> addr <= addr+1 (mod 128), go to READ.
//     DONE: done=1 for one cycle, busy still 1; go to IDLE.
//   Latency: start sampled in cycle N -> dmem_rden in N+1 -> first tx_valid in N+3.
//   Each word boundary adds a 2-cycle tx_valid bubble (READ, WAIT).
//   With tx_ready held high, a full image takes 2*words + NUM_PIXELS cycles from READ entry to DONE.
//   Backpressure: while tx_valid && !tx_ready, tx_data, buf, counters and state are unchanged.
//   tx_valid never drops without a handshake.
//   start outside IDLE (including in DONE) is ignored. It is not queued.
//   Partial last word: bytes past NUM_PIXELS are never presented.
//   Address wrap: BASE_ADDR + words - 1 > 127 wraps to 0 silently. No error flag.
//   Reset mid-operation: immediate return to IDLE with all outputs 0. The image is abandoned.
//   The next start restarts from pixel 0.
//   dmem_rddata is sampled only in WAIT. It is ignored in every other state.
// TESTING
//   T1 Full image: DMEM word k, byte j = (32k+j)&0xFF; tx_ready=1; start pulse.
//      -> 25 rden pulses at addresses 0..24; bytes 0x00..0xFF repeating, 784 total.
//      -> pix_cnt ends at 784; done pulses once, 834 cycles after READ entry.
//   T2 Backpressure: tx_ready low 10 cycles at pixel 40, then toggling every cycle.
//      -> tx_data holds 0x28 while stalled; no pixel dropped or duplicated; order preserved.
//   T3 start asserted during SEND and during DONE.
//      -> ignored, exactly one image streamed; start on the cycle after DONE launches a new image.
//   T4 rst_n low for 1 cycle at pixel 100.
//      -> all outputs 0 asynchronously, state IDLE.
//      -> next start streams from pixel 0 and reads address BASE_ADDR first.
//   T5 BASE_ADDR=100, NUM_PIXELS=1024.
//      -> rden addresses 100..127 then 0..3; 1024 bytes; done once.
//   T6 NUM_PIXELS=1.
//      -> one rden at BASE_ADDR; a single byte equal to word[7:0]; done follows the handshake.

Source files
------------

// File: rtl/dmem_img_reader.sv
// Streams a packed-byte image out of DMEM: one 256-bit word per read, 32 pixels
// per word, byte 0 first, presented on a valid/ready byte interface.
module dmem_img_reader #(
  parameter logic [6:0] BASE_ADDR  = 7'd0,
  parameter int         NUM_PIXELS = 784
) (
  input  logic         CLOCK_50,
  input  logic         rst_n,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic         dmem_rden,
  output logic [6:0]   dmem_rdaddr,
  input  logic [255:0] dmem_rddata,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic [11:0]  pix_cnt
);

  localparam logic [11:0] LAST_PIX = 12'(NUM_PIXELS - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_WAIT = 3'd2,
    S_SEND = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t         state_r, state_s;
  logic [255:0]   buf_r, buf_s;
  logic [4:0]     byte_idx_r, byte_idx_s;
  logic [6:0]     addr_r, addr_s;
  logic [11:0]    pix_cnt_r, pix_cnt_s;
  logic           busy_r, done_r, rden_r, valid_r;
  logic           handshake_s;

  // valid_r mirrors state SEND, so a handshake is simply SEND with ready
  assign handshake_s = (state_r == S_SEND) && tx_ready;

  // next-state and datapath update
  always_comb begin
    state_s    = state_r;
    buf_s      = buf_r;
    byte_idx_s = byte_idx_r;
    addr_s     = addr_r;
    pix_cnt_s  = pix_cnt_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          pix_cnt_s  = 12'd0;
          byte_idx_s = 5'd0;
          addr_s     = BASE_ADDR;
          state_s    = S_READ;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_READ: begin
        state_s = S_WAIT;
      end
      S_WAIT: begin
        buf_s      = dmem_rddata;
        byte_idx_s = 5'd0;
        state_s    = S_SEND;
      end
      S_SEND: begin
        if (handshake_s) begin
          buf_s      = {8'd0, buf_r[255:8]};
          byte_idx_s = byte_idx_r + 5'd1;
          pix_cnt_s  = pix_cnt_r + 12'd1;
          // finishing the image wins over fetching the next word
          if (pix_cnt_r == LAST_PIX) begin
            state_s = S_DONE;
          end else if (byte_idx_r == 5'd31) begin
            addr_s  = addr_r + 7'd1;
            state_s = S_READ;
          end else begin
            state_s = S_SEND;
          end
        end else begin
          state_s = S_SEND;
        end
      end
      S_DONE: begin
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // state, datapath and output registers; outputs decode the next state
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      buf_r      <= 256'd0;
      byte_idx_r <= 5'd0;
      addr_r     <= 7'd0;
      pix_cnt_r  <= 12'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      rden_r     <= 1'b0;
      valid_r    <= 1'b0;
    end else begin
      state_r    <= state_s;
      buf_r      <= buf_s;
      byte_idx_r <= byte_idx_s;
      addr_r     <= addr_s;
      pix_cnt_r  <= pix_cnt_s;
      busy_r     <= (state_s != S_IDLE);
      done_r     <= (state_s == S_DONE);
      rden_r     <= (state_s == S_READ);
      valid_r    <= (state_s == S_SEND);
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign dmem_rden   = rden_r;
  assign dmem_rdaddr = addr_r;
  assign tx_data     = buf_r[7:0];
  assign tx_valid    = valid_r;
  assign pix_cnt     = pix_cnt_r;

endmodule

// File: tb/tb_dmem_img_reader.sv
// Bench for dmem_img_reader: three parameterisations share one DMEM array; a
// monitor logs handshakes/reads and an address/pixel model checks each image.
module tb_dmem_img_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [2:0]  start, busy, done, rden, tx_valid;
  logic        tx_ready;
  logic [6:0]  rdaddr [3];
  logic [7:0]  tx_data [3];
  logic [11:0] pix_cnt [3];
  logic [255:0] mem [128];

  genvar g;
  for (g = 0; g < 3; g++) begin : g_dut
    localparam logic [6:0] B = (g == 1) ? 7'd100 : ((g == 2) ? 7'd5 : 7'd0);
    localparam int         N = (g == 1) ? 1024 : ((g == 2) ? 1 : 784);
    logic [255:0] rd;
    dmem_img_reader #(.BASE_ADDR(B), .NUM_PIXELS(N)) u_dut (
      .CLOCK_50(clk), .rst_n(rst_n), .start(start[g]), .busy(busy[g]), .done(done[g]),
      .dmem_rden(rden[g]), .dmem_rdaddr(rdaddr[g]), .dmem_rddata(rd),
      .tx_data(tx_data[g]), .tx_valid(tx_valid[g]), .tx_ready(tx_ready), .pix_cnt(pix_cnt[g]));
    // garbage outside the data cycle exposes sampling in the wrong state
    always @(posedge clk) rd <= rden[g] ? mem[rdaddr[g]] : {8{32'hDEAD_BEEF}};
  end

  logic [7:0] got_q [$];
  logic [6:0] addr_q [$];
  int rden_cyc_q [$];
  int vrise_q [$];
  int cyc = 0, start_cyc = 0, done_cyc = 0, done_cnt = 0, stall_bad = 0;
  logic [2:0] stall_prev = 3'd0, prev_valid = 3'd0;
  logic [7:0] stall_data [3];
  int errors = 0, checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (start[k] && !busy[k] && rst_n) start_cyc <= cyc;
      if (rden[k]) begin
        addr_q.push_back(rdaddr[k]);
        rden_cyc_q.push_back(cyc);
      end
      if (tx_valid[k] && !prev_valid[k]) vrise_q.push_back(cyc);
      if (tx_valid[k] && tx_ready) got_q.push_back(tx_data[k]);
      if (done[k]) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
      if (stall_prev[k] && (!tx_valid[k] || tx_data[k] !== stall_data[k])) stall_bad <= stall_bad + 1;
      stall_prev[k] <= tx_valid[k] && !tx_ready && rst_n;
      stall_data[k] <= tx_data[k];
      prev_valid[k] <= tx_valid[k];
    end
  end

  function automatic int base_of(input int i);
    case (i)
      1: return 100;
      2: return 5;
      default: return 0;
    endcase
  endfunction

  function automatic bit outs_nonzero(input int i);
    return busy[i] | done[i] | rden[i] | tx_valid[i] | (|rdaddr[i]) | (|tx_data[i]) | (|pix_cnt[i]);
  endfunction

  task automatic check_val(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fill_mem(input bit rnd);
    for (int k = 0; k < 128; k++)
      for (int j = 0; j < 32; j++)
        mem[k][8*j +: 8] = rnd ? 8'($urandom) : 8'((32*k + j) & 255);
  endtask

  task automatic pulse_start(input int i);
    @(posedge clk); #1;
    start[i] = 1'b1;
    @(posedge clk); #1;
    start[i] = 1'b0;
  endtask

  task automatic wait_done_neg(input int i);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (done[i]) break;
    end
  endtask

  // reference: pixel p lives in word (base + p/32) mod 128, byte p mod 32
  task automatic compare_image(input int i, input int gb, input int ab,
                               input int nbytes, input int nwords, input int addr0);
    int bad, first;
    logic [7:0] e;
    check_val("byte_count", got_q.size() - gb, nbytes);
    bad = 0; first = -1;
    for (int p = 0; p < nbytes && gb + p < got_q.size(); p++) begin
      e = mem[(base_of(i) + p / 32) % 128][8*(p % 32) +: 8];
      if (got_q[gb + p] !== e) begin
        if (first < 0) first = p;
        bad++;
      end
    end
    check_val("pixel_data_mismatches", bad, 0);
    if (first >= 0) $display("  first bad pixel index %0d", first);
    check_val("rden_count", addr_q.size() - ab, nwords);
    bad = 0;
    for (int k = 0; k < nwords && ab + k < addr_q.size(); k++)
      if (int'(addr_q[ab + k]) != (base_of(i) + k) % 128) bad++;
    check_val("rden_addr_mismatches", bad, 0);
    check_val("first_rden_addr", (addr_q.size() > ab) ? int'(addr_q[ab]) : -1, addr0);
  endtask

  typedef struct {
    int inst; bit rnd; int mode;
    int exp_bytes; int exp_words; int exp_addr0; int exp_cycles; int exp_pix;
  } vec_t;
  vec_t tbl [6];

  initial begin
    int gb, ab, vb, d0, bad;
    tbl[0] = '{0, 1'b0, 0,  784, 25,   0,  834,  784};
    tbl[1] = '{0, 1'b1, 1,  784, 25,   0,   -1,  784};
    tbl[2] = '{1, 1'b0, 0, 1024, 32, 100, 1088, 1024};
    tbl[3] = '{1, 1'b1, 1, 1024, 32, 100,   -1, 1024};
    tbl[4] = '{2, 1'b1, 0,    1,  1,   5,    3,    1};
    tbl[5] = '{2, 1'b1, 1,    1,  1,   5,   -1,    1};

    rst_n = 1'b0; start = 3'd0; tx_ready = 1'b0;
    fill_mem(1'b0);
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) check_val("reset_outputs_zero", int'(outs_nonzero(i)), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int t = 0; t < 6; t++) begin
      fill_mem(tbl[t].rnd);
      gb = got_q.size(); ab = addr_q.size(); vb = vrise_q.size(); d0 = done_cnt;
      tx_ready = 1'b1;
      pulse_start(tbl[t].inst);
      for (int c = 0; c < 6000 && done_cnt == d0; c++) begin
        if (tbl[t].mode != 0) tx_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      tx_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check_val("done_pulses", done_cnt - d0, 1);
      compare_image(tbl[t].inst, gb, ab, tbl[t].exp_bytes, tbl[t].exp_words, tbl[t].exp_addr0);
      check_val("final_pix_cnt", int'(pix_cnt[tbl[t].inst]), tbl[t].exp_pix);
      check_val("start_to_rden", (addr_q.size() > ab) ? rden_cyc_q[ab] - start_cyc : -1, 1);
      check_val("start_to_valid", (vrise_q.size() > vb) ? vrise_q[vb] - start_cyc : -1, 3);
      if (tbl[t].exp_cycles >= 0)
        check_val("read_to_done_cycles", (addr_q.size() > ab) ? done_cyc - rden_cyc_q[ab] : -1, tbl[t].exp_cycles);
      check_val("idle_after_done", int'(busy[tbl[t].inst]), 0);
    end

    // backpressure at pixel 40, then ready toggling every cycle
    fill_mem(1'b0);
    gb = got_q.size(); ab = addr_q.size(); d0 = done_cnt;
    tx_ready = 1'b1;
    pulse_start(0);
    for (int c = 0; c < 500 && got_q.size() - gb < 40; c++) begin
      @(posedge clk); #1;
    end
    tx_ready = 1'b0;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!tx_valid[0] || tx_data[0] !== 8'h28) bad++;
    end
    check_val("stall_hold_0x28", bad, 0);
    check_val("stall_no_accept", got_q.size() - gb, 40);
    for (int c = 0; c < 4000 && done_cnt == d0; c++) begin
      @(posedge clk); #1;
      tx_ready = ~tx_ready;
    end
    tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("bp_done_pulses", done_cnt - d0, 1);
    compare_image(0, gb, ab, 784, 25, 0);

    // start during SEND and during DONE is ignored
    gb = got_q.size(); ab = addr_q.size(); d0 = done_cnt;
    pulse_start(0);
    repeat (10) @(posedge clk);
    #1; start[0] = 1'b1;
    @(posedge clk); #1; start[0] = 1'b0;
    wait_done_neg(0);
    start[0] = 1'b1;
    @(posedge clk); #1; start[0] = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check_val("ignored_start_done_pulses", done_cnt - d0, 1);
    check_val("ignored_start_busy", int'(busy[0]), 0);
    compare_image(0, gb, ab, 784, 25, 0);

    // start in the cycle right after DONE launches a fresh image
    pulse_start(0);
    wait_done_neg(0);
    @(posedge clk); #1;
    gb = got_q.size(); ab = addr_q.size(); d0 = done_cnt;
    start[0] = 1'b1;
    @(posedge clk); #1; start[0] = 1'b0;
    check_val("restart_after_done_busy", int'(busy[0]), 1);
    for (int c = 0; c < 3000 && done_cnt == d0; c++) begin
      @(posedge clk); #1;
    end
    repeat (3) @(posedge clk);
    #1;
    check_val("restart_done_pulses", done_cnt - d0, 1);
    compare_image(0, gb, ab, 784, 25, 0);

    // reset mid-image, then a clean restart from pixel 0
    fill_mem(1'b1);
    gb = got_q.size();
    pulse_start(0);
    for (int c = 0; c < 500 && got_q.size() - gb < 100; c++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #2;
    check_val("async_reset_outputs_zero", int'(outs_nonzero(0)), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("post_reset_idle", int'(busy[0]), 0);
    gb = got_q.size(); ab = addr_q.size(); d0 = done_cnt;
    pulse_start(0);
    for (int c = 0; c < 3000 && done_cnt == d0; c++) begin
      @(posedge clk); #1;
    end
    repeat (3) @(posedge clk);
    #1;
    check_val("post_reset_done_pulses", done_cnt - d0, 1);
    compare_image(0, gb, ab, 784, 25, 0);
    check_val("valid_hold_under_backpressure", stall_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
